pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Arbitrates these stall sources:
  - load-use/branch stalls from the hazard unit
  - data-memory wait states
  - a multi-cycle multiply/divide resource shared by mult/div/mfhi/mflo
- Drives per-stage register enables and bubble insertion.
- Sequences the mul/div latency counter and watches for dmem wait timeouts.
- Sits between the hazard unit, the memory interface and the pipeline registers.

Parameters:
- MULT_CYCLES, 4, latency of mult/multu from issue to HI/LO write (range 2..255).
- DIV_CYCLES, 32, latency of div/divu (range 2..255; must be ≥ MULT_CYCLES).
- DMEM_TIMEOUT, 64, maximum consecutive dmem wait cycles before the error state.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- hazard_stall  in  1  lwstall|branchstall from the hazard unit
- branch_taken_decode  in  1  branch/jump resolved taken in decode
- dmem_req_mem  in  1  load/store present in MEM
- dmem_ready  in  1  data memory completes the access this cycle
- muldiv_start_exe  in  1  mult/div instruction in EX
- muldiv_is_div_exe  in  1  1 = div latency, 0 = mult latency
- muldiv_use_decode  in  1  decode instruction is mult/div/mfhi/mflo
- stall_pc, stall_decode, stall_exe, stall_mem  out  1 each  hold the respective register
- flush_decode, flush_exe, flush_wb  out  1 each  load a bubble into IF/ID, ID/EX, MEM/WB
- muldiv_busy  out  1  mul/div in flight
- muldiv_done  out  1  one-cycle HI/LO write strobe
- dmem_timeout  out  1  sticky error flag
- ctrl_state  out  2  00 RUN, 01 DMEM_WAIT, 10 ERROR

Behaviour:
- Reset (sync, rst=1 at clk edge) produces:
  - ctrl_state=RUN, counter=0
  - muldiv_busy=0, muldiv_done=0, dmem_timeout=0
  - dmem wait counter=0
  - all stall/flush outputs 0 while rst is high
  - reset mid-operation aborts any mul/div in flight with no done pulse.
- Combinational terms:
  - dmem_stall = dmem_req_mem & ~dmem_ready
  - md_stall = muldiv_use_decode & (muldiv_busy | (muldiv_start_exe & ~dmem_stall))
- Output priority, highest first:
  - ERROR state: all four stalls=1, flush_wb=1, other flushes 0.
  - dmem_stall: stall_pc=stall_decode=stall_exe=stall_mem=1, flush_wb=1; flush_decode=flush_exe=0.
  - md_stall: stall_pc=stall_decode=1, flush_exe=1.
  - hazard_stall: stall_pc=stall_decode=1, flush_exe=1.
  - otherwise: all stalls 0; flush_decode=branch_taken_decode.
- branch_taken_decode is ignored (flush_decode=0) whenever any stall term above is active; decode retries the next cycle.
- FSM transitions:
  - RUN→DMEM_WAIT when dmem_stall; wait counter loads 1.
  - DMEM_WAIT stays while dmem_stall; counter increments.
  - DMEM_WAIT→RUN when dmem_ready=1 or dmem_req_mem=0.
  - DMEM_WAIT→ERROR when dmem_stall and counter==DMEM_TIMEOUT-1; dmem_timeout set.
  - ERROR is left only by rst.
- Mul/div issue:
  - Issue sampled at a clk edge with muldiv_start_exe=1, ~dmem_stall, state!=ERROR.
  - Counter loads (DIV_CYCLES or MULT_CYCLES)-1 and muldiv_busy=1.
  - Counter decrements every cycle, including during dmem stalls (independent resource).
  - When busy and counter==0: muldiv_done=1 for exactly one cycle and busy clears.
  - Timing: issue at edge t gives done high in cycle t+N-1 after that edge, i.e. exactly N cycles of busy including the done cycle.
  - Issue while busy (illegal; decode stall prevents it) restarts the counter with no done for the aborted op.
- Counter width: CNT_W=$clog2(DIV_CYCLES); no wrap (counter never decrements below 0).

Decomposition:
- Shared defines (alongside the existing defines): ctrl_state encodings RUN/DMEM_WAIT/ERROR and the default latency constants.
- One natural sub-module: muldiv_seq (issue/counter/busy/done), instantiated once; FSM and priority mux stay in the top.

Test Plan:
- Reset then idle inputs → all outputs 0, ctrl_state=00.
- hazard_stall=1 for 1 cycle → stall_pc=stall_decode=flush_exe=1 that cycle only; branch_taken_decode=1 simultaneously → flush_decode=0.
- dmem_req_mem=1, dmem_ready=0 for 3 cycles then 1 → four stalls + flush_wb for 3 cycles, ctrl_state=01 in cycles 2–3, RUN after ready.
- DMEM_TIMEOUT=8, dmem_ready held 0 → ctrl_state=10 and dmem_timeout=1 after 8 stall cycles; persists until rst.
- muldiv_start_exe with is_div=0 at edge t → busy for 4 cycles, done pulse in 4th; mfhi in decode during busy → md_stall until the cycle after done.
- Div issued, then dmem stall of 5 cycles mid-op → done still arrives exactly 32 cycles after issue; start asserted during the dmem stall is not accepted.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings and default latencies for the pipeline stall/flush scheduler.
package pipeline_stall_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN       = 2'b00,
      ST_DMEM_WAIT = 2'b01,
      ST_ERROR     = 2'b10
   } ctrl_state_e;

   localparam int DEF_MULT_CYCLES  = 4;
   localparam int DEF_DIV_CYCLES   = 32;
   localparam int DEF_DMEM_TIMEOUT = 64;

   // Per-stage hold/bubble controls, MSB first as they appear on the bus.
   typedef struct packed {
      logic stall_pc;
      logic stall_decode;
      logic stall_exe;
      logic stall_mem;
      logic flush_decode;
      logic flush_exe;
      logic flush_wb;
   } stall_ctl_t;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between hazard unit / memory interface and the stall scheduler.
interface pipeline_stall_ctrl_if;

   logic       hazard_stall;
   logic       branch_taken_decode;
   logic       dmem_req_mem;
   logic       dmem_ready;
   logic       muldiv_start_exe;
   logic       muldiv_is_div_exe;
   logic       muldiv_use_decode;
   logic       stall_pc;
   logic       stall_decode;
   logic       stall_exe;
   logic       stall_mem;
   logic       flush_decode;
   logic       flush_exe;
   logic       flush_wb;
   logic       muldiv_busy;
   logic       muldiv_done;
   logic       dmem_timeout;
   logic [1:0] ctrl_state;

   // Pipeline side: drives requests, consumes stall/flush controls.
   modport master (
      output hazard_stall, branch_taken_decode, dmem_req_mem, dmem_ready,
             muldiv_start_exe, muldiv_is_div_exe, muldiv_use_decode,
      input  stall_pc, stall_decode, stall_exe, stall_mem,
             flush_decode, flush_exe, flush_wb,
             muldiv_busy, muldiv_done, dmem_timeout, ctrl_state
   );

   // Scheduler side.
   modport slave (
      input  hazard_stall, branch_taken_decode, dmem_req_mem, dmem_ready,
             muldiv_start_exe, muldiv_is_div_exe, muldiv_use_decode,
      output stall_pc, stall_decode, stall_exe, stall_mem,
             flush_decode, flush_exe, flush_wb,
             muldiv_busy, muldiv_done, dmem_timeout, ctrl_state
   );

endinterface

// File: rtl/pipeline_stall_ctrl_muldiv_seq.sv
// Multiply/divide latency sequencer: issue loads a down-counter, done fires on
// the last busy cycle. Runs independently of pipeline stalls.
module muldiv_seq
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic issue,
   input  logic is_div,
   output logic busy,
   output logic done
);

   localparam int CNT_W = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Load on issue (a re-issue simply restarts), count down, drop busy after the done cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (issue) begin
         busy <= 1'b1;
         cnt  <= is_div ? DIV_LD : MULT_LD;
      end else if (busy) begin
         if (cnt == '0)
            busy <= 1'b0;
         else
            cnt <= cnt - CNT_W'(1);
      end
   end

   // Done is decoded from registered state, so it is a clean one-cycle strobe.
   assign done = busy & (cnt == '0);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: dmem wait FSM with
// timeout, mul/div resource tracking and the stall/flush priority mux.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES  = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES   = DEF_DIV_CYCLES,
   parameter int DMEM_TIMEOUT = DEF_DMEM_TIMEOUT
) (
   input logic                 clk,
   input logic                 rst,
   pipeline_stall_ctrl_if.slave bus
);

   localparam int WCNT_W = $clog2(DMEM_TIMEOUT + 1);

   ctrl_state_e       state;
   logic [WCNT_W-1:0] wcnt;
   logic              timeout_q;
   logic              dmem_stall;
   logic              md_stall;
   logic              issue;
   logic              busy;
   logic              done;
   stall_ctl_t        ctl;

   assign dmem_stall = bus.dmem_req_mem & ~bus.dmem_ready;
   // A mul/div entering EX this cycle only blocks decode if it actually issues.
   assign md_stall   = bus.muldiv_use_decode & (busy | (bus.muldiv_start_exe & ~dmem_stall));
   assign issue      = bus.muldiv_start_exe & ~dmem_stall & (state != ST_ERROR);

   muldiv_seq #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_muldiv_seq (
      .clk    (clk),
      .rst    (rst),
      .issue  (issue),
      .is_div (bus.muldiv_is_div_exe),
      .busy   (busy),
      .done   (done)
   );

   // Dmem wait tracking; ERROR is terminal until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         wcnt      <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (dmem_stall) begin
                  state <= ST_DMEM_WAIT;
                  wcnt  <= WCNT_W'(1);
               end
            end
            ST_DMEM_WAIT: begin
               if (!dmem_stall) begin
                  state <= ST_RUN;
                  wcnt  <= '0;
               end else if (wcnt == WCNT_W'(DMEM_TIMEOUT - 1)) begin
                  state     <= ST_ERROR;
                  timeout_q <= 1'b1;
               end else begin
                  wcnt <= wcnt + WCNT_W'(1);
               end
            end
            ST_ERROR: begin
               state <= ST_ERROR;
            end
            default: begin
               state <= ST_RUN;
               wcnt  <= '0;
            end
         endcase
      end
   end

   // Priority mux: error > dmem wait > mul/div > hazard > branch flush.
   always_comb begin
      ctl = '0;
      if (rst) begin
         ctl = '0;
      end else if (state == ST_ERROR || dmem_stall) begin
         ctl.stall_pc     = 1'b1;
         ctl.stall_decode = 1'b1;
         ctl.stall_exe    = 1'b1;
         ctl.stall_mem    = 1'b1;
         ctl.flush_wb     = 1'b1;
      end else if (md_stall || bus.hazard_stall) begin
         ctl.stall_pc     = 1'b1;
         ctl.stall_decode = 1'b1;
         ctl.flush_exe    = 1'b1;
      end else begin
         ctl.flush_decode = bus.branch_taken_decode;
      end
   end

   assign bus.stall_pc     = ctl.stall_pc;
   assign bus.stall_decode = ctl.stall_decode;
   assign bus.stall_exe    = ctl.stall_exe;
   assign bus.stall_mem    = ctl.stall_mem;
   assign bus.flush_decode = ctl.flush_decode;
   assign bus.flush_exe    = ctl.flush_exe;
   assign bus.flush_wb     = ctl.flush_wb;
   assign bus.muldiv_busy  = busy;
   assign bus.muldiv_done  = done;
   assign bus.dmem_timeout = timeout_q;
   assign bus.ctrl_state   = state;

endmodule
